load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the single-cycle core's execute stage and the word-wide data memory.
//  - Converts RV32I byte/halfword/word loads and stores into word accesses.
//  - Performs read-modify-write for SB/SH, sign/zero-extends load data.
//  - Flags misaligned, out-of-range and illegal-funct3 accesses.
//  - Uses a valid/ready request channel and a one-cycle response pulse.
// PARAMETERS
//  MEM_DEPTH  1024  data memory depth in 32-bit words; word index >= MEM_DEPTH -> error
//  IDX_W      10    width of the word index, = clog2(MEM_DEPTH)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   core presents an access
//  req_ready  out  1   LSU can accept; high only in IDLE
//  req_we     in   1   1 = store, 0 = load
//  req_funct3 in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data (rs2)
//  rsp_valid  out  1   one-cycle pulse, access complete
//  rsp_rdata  out  32  formatted load data; 0 for stores and errors
//  rsp_err    out  1   valid with rsp_valid: misaligned / out of range / illegal funct3
//  mem_A      out  32  word index to data memory = {22'b0, addr[11:2]} (zero-extended IDX_W field)
//  mem_WD     out  32  write data (merged word)
//  mem_WE     out  1   write enable, sampled by memory on posedge
//  mem_RD     in   32  combinational read data for mem_A
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, all latches cleared.
//  mem_WE is gated by ~rst combinationally, so no write occurs in any cycle with rst high.
//  FSM states and transitions:
//  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and check the request.
//    - On error -> RESP with err.
//    - LW or any load -> RD.
//    - SW -> WR.
//    - SB/SH -> RD.
//  - RD: mem_A = latched index; capture mem_RD into rbuf.
//    - Load: format into rdata -> RESP.
//    - Store: merge -> WR.
//  - WR: mem_WE=1, mem_WD = merged word (SW: wdata unchanged) -> RESP.
//  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. req_ready=0, so back-to-back
//    requests are accepted no earlier than the cycle after RESP.
//  Latency, counted from the acceptance edge T:
//  - Loads and SW: rsp_valid at T+2.
//  - SB/SH: rsp_valid at T+3.
//  - Errors: rsp_valid at T+1.
//  Error checks:
//  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
//  - Out of range: addr[31:2] >= MEM_DEPTH.
//  - Illegal funct3: loads 011/110/111; stores with funct3[2]=1 or 011.
//  - Any error: memory untouched (mem_WE stays 0), rsp_rdata=0.
//  Load formatting:
//  - Byte lane = addr[1:0]; halfword lane = addr[1].
//  - LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend; LW passes through.
//  Store merging: SB replaces byte lane addr[1:0] of rbuf; SH replaces halfword lane addr[1].
//  mem_A/mem_WD hold the latched values in all non-IDLE states and are 0 in IDLE.
//  Reset mid-operation: the access is abandoned and no response is issued. A pending
//  SB/SH write in WR is suppressed by the ~rst gate.
// CONFIGURATION
//  LSU_PERF_CNT_EN defined:
//  - Adds outputs cnt_load, cnt_store, cnt_err (32 bits each).
//  - Each counter increments in RESP for its class; errors count only in cnt_err.
//  - Counters clear on rst and wrap modulo 2^32.
//  LSU_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. Preload word[28]=0x00000020; LW addr=0x70 -> rsp_valid at T+2, rdata=0x00000020, err=0.
//  2. Preload word[40]=0x80FF0002; LB 0xA3 -> 0xFFFFFF80; LBU 0xA3 -> 0x00000080;
//     LH 0xA0 -> 0x00000002; LHU 0xA2 -> 0x000080FF.
//  3. word[5]=0x11223344; SB addr=0x15, wdata=0xAB -> mem_WE one cycle at T+2,
//     word[5]=0x1122AB44, rsp at T+3.
//  4. SH addr=0x13 -> rsp_err=1 at T+1, mem_WE never high; LW addr=0x1000 (index 1024) -> err=1.
//  5. Assert rst while in WR of an SB -> no write, rsp_valid stays 0, req_ready=1 the cycle
//     after rst falls.
//  6. With LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> cnt_load=3, cnt_store=2, cnt_err=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response channel between the core and the LSU, plus the word-wide data-memory bus.
// The slave modport is the LSU's view. The master modport is the core/memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/halfword/word accesses mapped onto a word memory, with RMW for SB/SH.
// Optional LSU_PERF_CNT_EN adds load/store/error counters.
module load_store_unit #(
   parameter int MEM_DEPTH = 1024,
   parameter int IDX_W     = 10
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   bus
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [31:0]        cnt_load,
   output logic [31:0]        cnt_store,
   output logic [31:0]        cnt_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t             r_state;
   logic               r_we;
   logic [2:0]         r_f3;
   logic [1:0]         r_lane;
   logic [IDX_W-1:0]   r_idx;
   logic [31:0]        r_mem_wd;
   logic               r_mem_we;
   logic               r_ready;
   logic               r_rsp_valid;
   logic [31:0]        r_rdata;
   logic               r_err;
   logic               w_bad;

   // Any illegal funct3, misalignment or out-of-range word index rejects the request.
   function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      logic bad_f3;
      logic misal;
      logic oor;
      if (we)
         bad_f3 = f3[2] | (f3 == 3'b011);
      else
         bad_f3 = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
      misal = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      oor   = {2'b00, addr[31:2]} >= 32'(MEM_DEPTH);
      return bad_f3 | misal | oor;
   endfunction

   function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [2:0] f3,
                                            input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*lane +: 8];
      h = lane[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'b0, b};
         3'b101:  return {16'b0, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [2:0] f3, input logic [1:0] lane);
      logic [31:0] res;
      res = old;
      case (f3[1:0])
         2'b00:   res[8*lane +: 8]       = wd[7:0];
         2'b01:   res[16*lane[1] +: 16]  = wd[15:0];
         default: res                    = wd;
      endcase
      return res;
   endfunction

   assign w_bad = req_bad(bus.req_we, bus.req_funct3, bus.req_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_f3        <= 3'b0;
         r_lane      <= 2'b0;
         r_idx       <= '0;
         r_mem_wd    <= 32'b0;
         r_mem_we    <= 1'b0;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 32'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_we     <= bus.req_we;
                  r_f3     <= bus.req_funct3;
                  r_lane   <= bus.req_addr[1:0];
                  r_idx    <= bus.req_addr[IDX_W+1:2];
                  r_mem_wd <= bus.req_wdata;
                  r_ready  <= 1'b0;
                  if (w_bad) begin
                     r_err       <= 1'b1;
                     r_rdata     <= 32'b0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else if (!bus.req_we || bus.req_funct3[1:0] != 2'b10) begin
                     r_state <= S_RD;
                  end else begin
                     r_mem_we <= 1'b1;
                     r_state  <= S_WR;
                  end
               end
            end
            // Loads finish here; sub-word stores merge into the fetched word.
            S_RD: begin
               if (!r_we) begin
                  r_rdata     <= fmt_load(bus.mem_RD, r_f3, r_lane);
                  r_err       <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_mem_wd <= merge_store(bus.mem_RD, r_mem_wd, r_f3, r_lane);
                  r_mem_we <= 1'b1;
                  r_state  <= S_WR;
               end
            end
            S_WR: begin
               r_mem_we    <= 1'b0;
               r_rdata     <= 32'b0;
               r_err       <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_rdata     <= 32'b0;
               r_err       <= 1'b0;
               r_idx       <= '0;
               r_mem_wd    <= 32'b0;
               r_ready     <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

`ifdef LSU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_load  <= 32'b0;
         cnt_store <= 32'b0;
         cnt_err   <= 32'b0;
      end else if (r_state == S_RESP) begin
         if (r_err)
            cnt_err <= cnt_err + 32'd1;
         else if (r_we)
            cnt_store <= cnt_store + 32'd1;
         else
            cnt_load <= cnt_load + 32'd1;
      end
   end
`endif

   assign bus.req_ready = r_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;
   assign bus.mem_A     = {{(32-IDX_W){1'b0}}, r_idx};
   assign bus.mem_WD    = r_mem_wd;
   // Gate with reset so an abandoned RMW never reaches memory.
   assign bus.mem_WE    = r_mem_we & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   load_store_unit_if bus ();

`ifdef LSU_PERF_CNT_EN
   logic [31:0] cnt_load, cnt_store, cnt_err;
`endif

   load_store_unit #(.MEM_DEPTH(1024), .IDX_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef LSU_PERF_CNT_EN
      ,
      .cnt_load  (cnt_load),
      .cnt_store (cnt_store),
      .cnt_err   (cnt_err)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (bus.mem_WE) mem[bus.mem_A[9:0]] <= bus.mem_WD;
   end
   assign bus.mem_RD = (bus.mem_A < 32'd1024) ? mem[bus.mem_A[9:0]] : 32'h0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wes;
   } vec_t;

   vec_t vt[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int wes);
      int g;
      rd = 0; er = 0; lat = 0; wes = 0; g = 0;
      @(negedge clk);
      while (!bus.req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (g >= 20) begin
         total++; bad++;
         $display("FAIL ready_wait: req_ready stayed 0 for %0d cycles, expected 1", g);
      end
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 1) chk("busy_ready", {31'b0, bus.req_ready}, 32'd0);
         if (bus.mem_WE) wes++;
         if (bus.rsp_valid) begin
            rd = bus.rsp_rdata; er = bus.rsp_err; lat = k;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat == 0) begin
         total++; bad++;
         $display("FAIL rsp_timeout: no rsp_valid within 8 cycles, expected one");
      end
      @(posedge clk); #1;
      chk("rsp_pulse", {31'b0, bus.rsp_valid}, 32'd0);
      chk("idle_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("idle_memA", bus.mem_A, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, wes;
      int          n_ld, n_st, n_er;

      n_ld = 0; n_st = 0; n_er = 0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
      bus.req_addr = 32'b0; bus.req_wdata = 32'b0;

      vt[0]  = '{1'b0, 3'b010, 32'h070, 32'h0,        32'h00000020, 1'b0, 2, 0};
      vt[1]  = '{1'b0, 3'b000, 32'h0A3, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
      vt[2]  = '{1'b0, 3'b100, 32'h0A3, 32'h0,        32'h00000080, 1'b0, 2, 0};
      vt[3]  = '{1'b0, 3'b001, 32'h0A0, 32'h0,        32'h00000002, 1'b0, 2, 0};
      vt[4]  = '{1'b0, 3'b101, 32'h0A2, 32'h0,        32'h000080FF, 1'b0, 2, 0};
      vt[5]  = '{1'b0, 3'b001, 32'h0A2, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0};
      vt[6]  = '{1'b0, 3'b000, 32'h0A2, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0};
      vt[7]  = '{1'b0, 3'b100, 32'h0A1, 32'h0,        32'h00000000, 1'b0, 2, 0};
      vt[8]  = '{1'b1, 3'b000, 32'h015, 32'h000000AB, 32'h00000000, 1'b0, 3, 1};
      vt[9]  = '{1'b0, 3'b010, 32'h014, 32'h0,        32'h1122AB44, 1'b0, 2, 0};
      vt[10] = '{1'b1, 3'b001, 32'h013, 32'h0000BEEF, 32'h00000000, 1'b1, 1, 0};
      vt[11] = '{1'b0, 3'b010, 32'h1000, 32'h0,       32'h00000000, 1'b1, 1, 0};
      vt[12] = '{1'b1, 3'b010, 32'h018, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1};
      vt[13] = '{1'b1, 3'b001, 32'h01E, 32'h12345566, 32'h00000000, 1'b0, 3, 1};
      vt[14] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h00000000, 1'b1, 1, 0};
      vt[15] = '{1'b1, 3'b100, 32'h000, 32'h0,        32'h00000000, 1'b1, 1, 0};
      vt[16] = '{1'b0, 3'b010, 32'hFFC, 32'h0,        32'h12345678, 1'b0, 2, 0};
      vt[17] = '{1'b0, 3'b010, 32'h072, 32'h0,        32'h00000000, 1'b1, 1, 0};

      // Preload while reset holds the LSU idle.
      preload(10'd28,   32'h00000020);
      preload(10'd40,   32'h80FF0002);
      preload(10'd5,    32'h11223344);
      preload(10'd6,    32'hCAFEBABE);
      preload(10'd7,    32'h01020304);
      preload(10'd8,    32'hAAAAAAAA);
      preload(10'd1023, 32'h12345678);

      chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_rdata",     bus.rsp_rdata, 32'd0);
      chk("rst_err",       {31'b0, bus.rsp_err}, 32'd0);
      chk("rst_mem_we",    {31'b0, bus.mem_WE}, 32'd0);
      chk("rst_mem_a",     bus.mem_A, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);

      for (int i = 0; i < 18; i++) begin
         run_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat, wes);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_we_cycles", i), 32'(wes), 32'(vt[i].exp_wes));
         if (vt[i].exp_err) n_er++;
         else if (vt[i].we) n_st++;
         else n_ld++;
      end

      chk("mem5_sb",  mem[5], 32'h1122AB44);
      chk("mem6_sw",  mem[6], 32'hDEADBEEF);
      chk("mem7_sh",  mem[7], 32'h55660304);
      chk("mem4_err_untouched", mem[4], mem[4] === 32'hx ? 32'hx : mem[4]);

`ifdef LSU_PERF_CNT_EN
      chk("cnt_load",  cnt_load,  32'(n_ld));
      chk("cnt_store", cnt_store, 32'(n_st));
      chk("cnt_err",   cnt_err,   32'(n_er));
`endif

      // Reset while an SB sits in its write cycle.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h11;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rmw_we_before_rst", {31'b0, bus.mem_WE}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_gates_we", {31'b0, bus.mem_WE}, 32'd0);
      @(posedge clk); #1;
      chk("rst_no_rsp0", {31'b0, bus.rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("rst_no_rsp1", {31'b0, bus.rsp_valid}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);
      chk("no_rsp_after_rst", {31'b0, bus.rsp_valid}, 32'd0);
      chk("mem8_no_write", mem[8], 32'hAAAAAAAA);
`ifdef LSU_PERF_CNT_EN
      chk("cnt_load_clr",  cnt_load,  32'd0);
      chk("cnt_store_clr", cnt_store, 32'd0);
      chk("cnt_err_clr",   cnt_err,   32'd0);
`endif

      run_req(1'b0, 3'b010, 32'h070, 32'h0, rd, er, lat, wes);
      chk("post_rst_lw", rd, 32'h00000020);
      chk("post_rst_lat", 32'(lat), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
